conv_phase_sequencer: RTL
=========================

// Module: conv_phase_sequencer
// PURPOSE
//  Parametrised successor of the accelerator controller. Sequences convolution windows through LOAD -> MULT -> ADD-tree levels -> STORE.
//  Adds configurable phase lengths and adder-tree depth, FIFO back-pressure on STORE, and an abort input.
//  Sits between the external start/status pins and the datapath; drives the input RAM, the filter ROM, the per-level datapath enables and the result FIFO.
// PARAMETERS
//  RAM_ADDR_W   10   input-matrix RAM address width
//  ROM_ADDR_W   4    filter-coefficient ROM address width
//  LOAD_CYC     2    cycles spent in LOAD per window (>=1)
//  MULT_CYC     16   cycles spent in MULT per window (>=1)
//  ADD_LEVELS   4    adder-tree levels; width of add_level_en (>=1)
//  ADD_CYC      8    cycles per adder level (>=1)
//  NUM_OUT      256  windows (FIFO writes) per job (>=1)
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           synchronous, active-high reset
//  start          in   1           job request; sampled only in IDLE
//  abort          in   1           cancel job; sampled in every state
//  fifo_full      in   1           result FIFO cannot accept a write
//  busy           out  1           1 in every state except IDLE
//  done           out  1           1-cycle pulse when the job completes
//  ram_en         out  1           input RAM enable (LOAD only)
//  ram_addr       out  RAM_ADDR_W  input RAM address
//  rom_en         out  1           filter ROM enable (LOAD only)
//  rom_addr       out  ROM_ADDR_W  filter ROM address
//  mult_en        out  1           multiplier array enable (MULT only)
//  add_level_en   out  ADD_LEVELS  one-hot adder-level enable (ADD only)
//  fifo_wr        out  1           result FIFO write strobe
//  fifo_rd        out  1           FIFO drain request, 1 cycle coincident with done
//  out_idx        out  clog2(NUM_OUT+1)  windows written so far in this job
// BEHAVIOUR
//  - All outputs are registered or decoded from registered state. No input reaches an output combinationally.
//  - Reset: state=IDLE; every output 0; all counters 0.
//  - States: IDLE, LOAD, MULT, ADD, STORE, FINISH.
//  - IDLE: start=1 at edge N -> LOAD from cycle N+1; ram_addr, rom_addr, out_idx and the level counter cleared.
//  - LOAD: stays LOAD_CYC cycles; ram_en=rom_en=1.
//    ram_addr and rom_addr advance +1 at each LOAD-cycle edge.
//    ram_addr is NOT cleared between windows; it is cleared only at job start.
//    rom_addr is cleared on each LOAD entry.
//    Both addresses wrap modulo 2^width silently.
//  - MULT: stays MULT_CYC cycles; mult_en=1.
//  - ADD: level counter L runs 0..ADD_LEVELS-1, ADD_CYC cycles each.
//    add_level_en = 1<<L. After the last cycle of the top level -> STORE.
//  - STORE, fifo_full=0: fifo_wr=1 for exactly one cycle, out_idx+1 at that edge.
//    If the new out_idx==NUM_OUT -> FINISH, else -> LOAD.
//  - STORE, fifo_full=1: hold in STORE with fifo_wr=0 for as many cycles as needed. No write is ever lost or duplicated.
//  - FINISH: one cycle; done=1, fifo_rd=1; then IDLE.
//  - abort=1 in any non-IDLE state: next state IDLE, no done, no fifo_wr that cycle, counters cleared.
//    Abort has priority over start, over the STORE write and over phase expiry.
//  - start while busy: ignored, no queuing. start and abort both high in IDLE: stay IDLE.
//  - reset mid-job: same effect as abort, plus all outputs 0.
//  - Minimum job length, no stalls: NUM_OUT*(LOAD_CYC+MULT_CYC+ADD_LEVELS*ADD_CYC+1)+1 cycles of busy.
// STRUCTURE
//  - Shared package: state enum (IDLE..FINISH); phase-length localparams; clog2-based counter widths.
//  - One sub-module, phase_timer: down-counter loaded with (len-1) on phase entry, asserts expire at 0.
//    One instance is shared by all timed phases. Everything else is inline FSM and counters.
// TESTING
//  - Defaults, NUM_OUT=2, fifo_full=0, start pulse
//    -> busy for 2*51+1=103 cycles, 2 fifo_wr pulses, done and fifo_rd together once.
//  - Check ram_addr across windows
//    -> window0 presents 0,1 and window1 presents 2,3; rom_addr presents 0,1 in both windows.
//  - fifo_full=1 for 5 cycles on entry to STORE
//    -> fifo_wr held 0 for 5 cycles, then a single pulse; out_idx increments once.
//  - abort raised mid-MULT of window 1
//    -> IDLE next cycle, busy=0, no done, next start restarts with ram_addr=0.
//  - start while busy, and start+abort together in IDLE -> both ignored; no state change.
//  - RAM_ADDR_W=2, LOAD_CYC=3, NUM_OUT=2
//    -> ram_addr sequence 0,1,2,3,0,1 (wraps); ADD_LEVELS=1 -> add_level_en stays 1'b1 throughout ADD.

Source files
------------

// File: rtl/conv_phase_sequencer_pkg.sv
// conv_phase_sequencer_pkg: shared state encoding, default phase lengths and counter-width helper
package conv_phase_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MULT, ADD, STORE, FINISH} state_t;
  localparam int LOAD_CYC_D = 2;
  localparam int MULT_CYC_D = 16;
  localparam int ADD_LEVELS_D = 4;
  localparam int ADD_CYC_D = 8;
  localparam int NUM_OUT_D = 256;
  function automatic int cw(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/conv_phase_sequencer_phase_timer.sv
// conv_phase_sequencer_phase_timer: down-counter loaded with (len-1), expire while it sits at 0
module conv_phase_sequencer_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= len;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expire = cnt == '0;
endmodule

// File: rtl/conv_phase_sequencer.sv
// conv_phase_sequencer: sequences convolution windows LOAD -> MULT -> ADD levels -> STORE with stall and abort
module conv_phase_sequencer
  import conv_phase_sequencer_pkg::*;
#(
  parameter int RAM_ADDR_W = 10,
  parameter int ROM_ADDR_W = 4,
  parameter int LOAD_CYC   = LOAD_CYC_D,
  parameter int MULT_CYC   = MULT_CYC_D,
  parameter int ADD_LEVELS = ADD_LEVELS_D,
  parameter int ADD_CYC    = ADD_CYC_D,
  parameter int NUM_OUT    = NUM_OUT_D
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         fifo_full,
  output logic                         busy,
  output logic                         done,
  output logic                         ram_en,
  output logic [RAM_ADDR_W-1:0]        ram_addr,
  output logic                         rom_en,
  output logic [ROM_ADDR_W-1:0]        rom_addr,
  output logic                         mult_en,
  output logic [ADD_LEVELS-1:0]        add_level_en,
  output logic                         fifo_wr,
  output logic                         fifo_rd,
  output logic [$clog2(NUM_OUT+1)-1:0] out_idx
);
  localparam int OW = $clog2(NUM_OUT + 1);
  localparam int LW = cw(ADD_LEVELS);
  localparam int TMAX = LOAD_CYC > MULT_CYC ? (LOAD_CYC > ADD_CYC ? LOAD_CYC : ADD_CYC)
                                            : (MULT_CYC > ADD_CYC ? MULT_CYC : ADD_CYC);
  localparam int TW = cw(TMAX);
  state_t state, state_n;
  logic [LW-1:0] lvl;
  logic [OW-1:0] nxt_idx;
  logic [TW-1:0] len;
  logic expire, last_lvl, wr, load, clr;
  assign nxt_idx  = out_idx + OW'(1);
  assign last_lvl = lvl == LW'(ADD_LEVELS - 1);
  assign wr       = state == STORE && !fifo_full && !abort;
  assign clr      = (abort && state != IDLE) || (state == IDLE && start && !abort);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = expire ? MULT : LOAD;
      MULT:    state_n = expire ? ADD : MULT;
      ADD:     state_n = expire && last_lvl ? STORE : ADD;
      STORE:   state_n = fifo_full ? STORE : nxt_idx == OW'(NUM_OUT) ? FINISH : LOAD;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // Timer reloads on every timed-phase entry and on each adder-level step
  assign load = (state_n != state && (state_n == LOAD || state_n == MULT || state_n == ADD))
             || (state == ADD && expire && !last_lvl);
  assign len  = state_n == LOAD ? TW'(LOAD_CYC - 1) : state_n == MULT ? TW'(MULT_CYC - 1) : TW'(ADD_CYC - 1);
  conv_phase_sequencer_phase_timer #(.W(TW)) phase_timer (
    .clk(clk), .reset(reset), .load(load), .len(len), .expire(expire)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state    <= IDLE;
      ram_addr <= '0;
      rom_addr <= '0;
      out_idx  <= '0;
      lvl      <= '0;
      fifo_wr  <= 1'b0;
    end else begin
      state   <= state_n;
      fifo_wr <= wr;
      if (clr) begin
        ram_addr <= '0;
        rom_addr <= '0;
        out_idx  <= '0;
        lvl      <= '0;
      end else begin
        if (state == LOAD) begin
          ram_addr <= ram_addr + 1'b1;
          rom_addr <= rom_addr + 1'b1;
        end
        if (state == STORE && state_n == LOAD) rom_addr <= '0;
        if (wr) out_idx <= nxt_idx;
        if (state == ADD && expire) lvl <= last_lvl ? '0 : lvl + 1'b1;
      end
    end
  assign busy         = state != IDLE;
  assign ram_en       = state == LOAD;
  assign rom_en       = state == LOAD;
  assign mult_en      = state == MULT;
  assign add_level_en = state == ADD ? ADD_LEVELS'(1) << lvl : '0;
  assign done         = state == FINISH;
  assign fifo_rd      = state == FINISH;
endmodule
